// File: rtl/regfile_mp_pkg.sv
// Shared defaults, zero word and clear/run state encoding for the multi-port register file.
package regfile_mp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wsel.sv
// Write-port select: reports whether any enabled write port targets a query address
// and returns its data, with the highest port index taking priority.
module regfile_wsel #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_WR = 1
) (
    input  logic [NUM_WR-1:0]      we_i,
    input  logic [NUM_WR*AW-1:0]   waddr_i,
    input  logic [NUM_WR*XLEN-1:0] wdata_i,
    input  logic [AW-1:0]          qaddr_i,
    output logic                   hit_o,
    output logic [XLEN-1:0]        data_o
);

    // Later ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (waddr_i[k*AW +: AW] == qaddr_i)) begin
                hit_o  = 1'b1;
                data_o = wdata_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and a
// post-reset clear engine that zeroes every register before the file is usable.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   waddr,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic [NUM_RD-1:0]      re,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic                   bset,
    input  logic [AW-1:0]          bset_addr
);

    state_e                       state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [NREGS-1:0][XLEN-1:0]   regs_q, regs_d;
    logic [NREGS-1:0]             busy_q, busy_d;

    logic [NUM_WR-1:0]            weGated;
    logic [NREGS-1:0]             wrHit;
    logic [NREGS-1:0][XLEN-1:0]   wrData;

    assign ready   = (state_q == RUN);
    assign weGated = ready ? we : '0;

    for (genvar r = 0; r < NREGS; r++) begin : g_wb
        regfile_wsel #(.XLEN(XLEN), .AW(AW), .NUM_WR(NUM_WR)) u_wsel (
            .we_i    (weGated),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .qaddr_i (AW'(r)),
            .hit_o   (wrHit[r]),
            .data_o  (wrData[r])
        );
    end

    // Clear engine walks cnt over every register; in RUN the writeback and
    // scoreboard update, with a same-cycle set overriding a clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        busy_d  = busy_q;
        if (state_q == CLEAR) begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wrHit[r]) begin
                    regs_d[r] = wrData[r];
                    busy_d[r] = 1'b0;
                end
                if (bset && (bset_addr == AW'(r))) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset of its own; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   rdAddr;
        logic            byHit;
        logic [XLEN-1:0] byData;
        logic            rdLive;

        assign rdAddr = raddr[i*AW +: AW];
        assign rdLive = ready && re[i] && (rdAddr != '0);

        regfile_wsel #(.XLEN(XLEN), .AW(AW), .NUM_WR(NUM_WR)) u_bypass (
            .we_i    (weGated),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .qaddr_i (rdAddr),
            .hit_o   (byHit),
            .data_o  (byData)
        );

        assign rdata[i*XLEN +: XLEN] = rdLive ? (byHit ? byData : regs_q[rdAddr])
                                              : XLEN'(ZERO_WORD);
        assign rbusy[i] = rdLive & busy_q[rdAddr] & ~byHit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp against a behavioural register-file model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ready;
    logic [NUM_WR-1:0]      we;
    logic [NUM_WR*AW-1:0]   waddr;
    logic [NUM_WR*XLEN-1:0] wdata;
    logic [NUM_RD-1:0]      re;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic [NUM_RD-1:0]      rbusy;
    logic                   bset;
    logic [AW-1:0]          bset_addr;

    int testCount = 0;
    int failCount = 0;

    logic [XLEN-1:0] mRegs [NREGS];
    bit              mBusy [NREGS];
    bit              mReady = 1'b0;
    int              mClearLeft = 0;
    bit              mInit = 1'b0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .bset      (bset),
        .bset_addr (bset_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic writeHits(input logic [AW-1:0] a);
        for (int k = 0; k < NUM_WR; k++)
            if (we[k] && waddr[k*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] expRead(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (!mReady || !re[i] || a == 0) return '0;
        for (int k = NUM_WR - 1; k >= 0; k--)
            if (we[k] && waddr[k*AW +: AW] == a) return wdata[k*XLEN +: XLEN];
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (!mReady || !re[i] || a == 0) return 1'b0;
        if (writeHits(a)) return 1'b0;
        return mBusy[a];
    endfunction

    // Model state advance at a clock edge, using the inputs held across it.
    function automatic void updateModel();
        if (rst) begin
            mInit      = 1'b1;
            mReady     = 1'b0;
            mClearLeft = NREGS;
            for (int r = 0; r < NREGS; r++) begin
                mRegs[r] = '0;
                mBusy[r] = 1'b0;
            end
        end else if (!mReady) begin
            mClearLeft--;
            if (mClearLeft == 0) mReady = 1'b1;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && waddr[k*AW +: AW] != 0) begin
                    mRegs[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
                    mBusy[waddr[k*AW +: AW]] = 1'b0;
                end
            end
            if (bset && bset_addr != 0) mBusy[bset_addr] = 1'b1;
        end
    endfunction

    task automatic applyStimulus(input logic rstI, input logic [1:0] weI,
                                 input logic [4:0] wa0, input logic [4:0] wa1,
                                 input logic [31:0] wd0, input logic [31:0] wd1,
                                 input logic [1:0] reI, input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic bs, input logic [4:0] ba);
        rst       = rstI;
        we        = weI;
        waddr     = {wa1, wa0};
        wdata     = {wd1, wd0};
        re        = reI;
        raddr     = {ra1, ra0};
        bset      = bs;
        bset_addr = ba;
        #1;
        if (mInit) begin
            checkOutput("ready", {31'b0, ready}, {31'b0, mReady});
            for (int i = 0; i < NUM_RD; i++) begin
                checkOutput($sformatf("rdata%0d", i), rdata[i*XLEN +: XLEN], expRead(i));
                checkOutput($sformatf("rbusy%0d", i), {31'b0, rbusy[i]}, {31'b0, expBusy(i)});
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(3) == 0) return 5'($urandom_range(31));
        return 5'($urandom_range(7));
    endfunction

    task automatic randomCycle(input int rstOneIn);
        logic r;
        r = (rstOneIn > 0) && ($urandom_range(rstOneIn - 1) == 0);
        applyStimulus(r, 2'($urandom_range(3)), randAddr(), randAddr(), $urandom, $urandom,
                      2'($urandom_range(3)), randAddr(), randAddr(),
                      ($urandom_range(3) == 0), randAddr());
    endtask

    task automatic measureClear(input string tag);
        int n;
        n = 0;
        randomCycle(0);
        while (!ready && n < 100) begin
            advance();
            n++;
            randomCycle(0);
        end
        checkOutput(tag, n, 32);
    endtask

    initial begin
        repeat (3) begin
            applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
            advance();
        end
        measureClear("readyLatency");

        for (int r = 0; r < NREGS; r += 2) begin
            applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'(r), 5'(r + 1), 1'b0, 5'd0);
            checkOutput($sformatf("clr_x%0d", r), rdata[31:0], 32'h0);
            checkOutput($sformatf("clr_x%0d", r + 1), rdata[63:32], 32'h0);
            advance();
        end

        applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        advance();
        repeat (10) begin
            randomCycle(0);
            advance();
        end
        applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        advance();
        measureClear("readyLatencyRestart");
        advance();

        applyStimulus(1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0);
        checkOutput("x5_p0", rdata[31:0], 32'hDEADBEEF);
        checkOutput("x5_p1", rdata[63:32], 32'hDEADBEEF);
        advance();

        applyStimulus(1'b0, 2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_zero", rdata[31:0], 32'h0);
        advance();

        applyStimulus(1'b0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
        checkOutput("bypass_x7", rdata[31:0], 32'h22);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b10, 5'd0, 5'd7, 1'b0, 5'd0);
        checkOutput("prio_x7", rdata[63:32], 32'h22);
        advance();

        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("busy_x9", {31'b0, rbusy[0]}, 32'h1);
        applyStimulus(1'b0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h55, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("busy_x9_wr", {31'b0, rbusy[0]}, 32'h0);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("busy_x9_clr", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("data_x9", rdata[31:0], 32'h55);
        advance();

        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        advance();
        applyStimulus(1'b0, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd3, 5'd0, 1'b1, 5'd0);
        checkOutput("collide_x3", {31'b0, rbusy[0]}, 32'h1);
        checkOutput("data_x3", rdata[31:0], 32'h33);
        advance();
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("busy_x0", {31'b0, rbusy[1]}, 32'h0);
        advance();

        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd3, 1'b0, 5'd0);
        checkOutput("gate_data", rdata[31:0], 32'h0);
        checkOutput("gate_busy", {30'b0, rbusy}, 32'h0);
        advance();

        for (int c = 0; c < 600; c++) begin
            randomCycle(60);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
